// File: rtl/mips_defs.sv
// mips_defs: shared store opcodes, store FSM state encoding and byte-enable masks.
// Contents: OP_SB/OP_SH/OP_SW opcodes, BE_* byte masks, st_state_t FSM states,
//           store_legal() opcode/alignment check used on request accept.
package mips_defs;

    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_ERR} st_state_t;

    // Known opcode with natural alignment for its size.
    function automatic logic store_legal(input logic [5:0] op, input logic [1:0] lo);
        return (op == OP_SB) || (op == OP_SH && !lo[0]) || (op == OP_SW && lo == 2'b00);
    endfunction

endpackage

// File: rtl/st_merge.sv
// st_merge: byte-mask generation and read-modify-write merge for sub-word stores.
// Ports: op (store opcode), addr_lo (byte offset), old_word (word read from memory),
//        wdata (right-aligned store data) -> merged (word to write), mask (bytes stored).
module st_merge
    import mips_defs::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [3:0]  mask
);

    logic [31:0] rep;

    // Replicate the store data across the word so each enabled lane already holds it.
    always_comb begin
        mask = (op == OP_SW) ? BE_WORD :
               (op == OP_SH) ? (addr_lo[1] ? BE_HI : BE_LO) :
               (op == OP_SB) ? 4'(BE_B0 << addr_lo) : BE_NONE;
        rep  = (op == OP_SB) ? {4{wdata[7:0]}} :
               (op == OP_SH) ? {2{wdata[15:0]}} : wdata;
        merged = old_word;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = mask[i] ? rep[8*i +: 8] : old_word[8*i +: 8];
    end

endmodule

// File: rtl/dm_store_unit.sv
// dm_store_unit: byte/half/word store engine doing read-modify-write on a word memory.
// Ports: clk, reset (sync, active-low); req_valid/req_ready + storeOp/addr/wdata request;
//        mem_addr, mem_rd_en/mem_rdata (RD_LATENCY-cycle read), mem_wr_en/mem_wdata/mem_be
//        (full-word write, be is debug only); st_done/st_err single-cycle completion pulses.
module dm_store_unit #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  storeOp,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr_en,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        st_done,
    output logic        st_err
);

    import mips_defs::*;

    st_state_t   state;
    logic [5:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  cnt;
    logic [5:0]  mrg_op;
    logic [1:0]  mrg_lo;
    logic [31:0] mrg_wdata;
    logic [31:0] merged;
    logic [3:0]  mask;

    assign req_ready = (state == S_IDLE);
    assign mem_addr  = {addr_q[31:2], 2'b00};

    // In IDLE the merger sees the incoming request (SW writes straight away);
    // otherwise it sees the latched request and the returning memory word.
    always_comb begin
        mrg_op    = req_ready ? storeOp    : op_q;
        mrg_lo    = req_ready ? addr[1:0]  : addr_q[1:0];
        mrg_wdata = req_ready ? wdata      : wdata_q;
    end

    st_merge u_merge (
        .op       (mrg_op),
        .addr_lo  (mrg_lo),
        .old_word (mem_rdata),
        .wdata    (mrg_wdata),
        .merged   (merged),
        .mask     (mask)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wdata <= '0;
            mem_be    <= BE_NONE;
            st_done   <= 1'b0;
            st_err    <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_be    <= BE_NONE;
            st_done   <= 1'b0;
            st_err    <= 1'b0;
            case (state)
                S_IDLE: if (req_valid) begin
                    op_q    <= storeOp;
                    addr_q  <= addr;
                    wdata_q <= wdata;
                    if (!store_legal(storeOp, addr[1:0])) begin
                        state  <= S_ERR;
                        st_err <= 1'b1;
                    end else if (storeOp == OP_SW) begin
                        state     <= S_WRITE;
                        mem_wr_en <= 1'b1;
                        st_done   <= 1'b1;
                        mem_wdata <= merged;
                        mem_be    <= mask;
                    end else begin
                        state     <= S_READ;
                        mem_rd_en <= 1'b1;
                    end
                end
                S_READ: begin
                    state <= S_WAIT;
                    cnt   <= 2'(RD_LATENCY - 1);
                end
                // Read data is valid in the last WAIT cycle; capture the merge then.
                S_WAIT: if (cnt == 2'd0) begin
                    state     <= S_WRITE;
                    mem_wr_en <= 1'b1;
                    st_done   <= 1'b1;
                    mem_wdata <= merged;
                    mem_be    <= mask;
                end else begin
                    cnt <= cnt - 2'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
